// File: rtl/sys_ctrl_pkg.sv
// Shared constants, command codes and FSM state encoding for the system controller.
package sys_ctrl_pkg;
   localparam int DATA_WIDTH    = 8;
   localparam int ADDR_WIDTH    = 4;
   localparam int ALU_OUT_WIDTH = 16;
   localparam int FUN_WIDTH     = 4;

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA;
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_WP = 8'hCC;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = 8'hDD;

   localparam logic [ADDR_WIDTH-1:0] OP_A_ADDR = 4'd0;
   localparam logic [ADDR_WIDTH-1:0] OP_B_ADDR = 4'd1;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A,
      ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB
   } state_t;
endpackage

// File: rtl/sys_ctrl_if.sv
// Bundle of RX, register-file, ALU and TX FIFO signals around the controller.
interface sys_ctrl_if;
   import sys_ctrl_pkg::*;

   logic [DATA_WIDTH-1:0]    rx_p_data;
   logic                     rx_d_vld;
   logic [ADDR_WIDTH-1:0]    rf_addr;
   logic [DATA_WIDTH-1:0]    rf_wr_data;
   logic                     rf_wr_en;
   logic                     rf_rd_en;
   logic [DATA_WIDTH-1:0]    rf_rd_data;
   logic                     rf_rd_data_vld;
   logic                     alu_en;
   logic [FUN_WIDTH-1:0]     alu_fun;
   logic [ALU_OUT_WIDTH-1:0] alu_out;
   logic                     alu_out_vld;
   logic                     clk_gate_en;
   logic [DATA_WIDTH-1:0]    tx_p_data;
   logic                     tx_d_vld;
   logic                     fifo_full;

   modport master (
      input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, fifo_full,
      output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_en, alu_fun, clk_gate_en,
             tx_p_data, tx_d_vld
   );

   modport slave (
      output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, fifo_full,
      input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_en, alu_fun, clk_gate_en,
             tx_p_data, tx_d_vld
   );
endinterface

// File: rtl/sys_ctrl_tx_push.sv
// TX FIFO push stage: holds one byte, emits a one-cycle strobe once the FIFO has room.
module sys_ctrl_tx_push
   import sys_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  fifo_full,
   output logic [DATA_WIDTH-1:0] tx_p_data,
   output logic                  tx_d_vld,
   output logic                  done
);
   logic pend;

   // The push is visible on the port in the same cycle the FSM is told it is done.
   assign done = tx_d_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_p_data <= '0;
         tx_d_vld  <= 1'b0;
         pend      <= 1'b0;
      end else begin
         tx_d_vld <= 1'b0;
         if (load) begin
            tx_p_data <= din;
            tx_d_vld  <= !fifo_full;
            pend      <= fifo_full;
         end else if (pend && !fifo_full) begin
            tx_d_vld <= 1'b1;
            pend     <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/sys_ctrl.sv
// Command parser/sequencer between UART RX, register file, ALU and the TX FIFO.
module sys_ctrl
   import sys_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   sys_ctrl_if.master bus
);
   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] res_hi;
   logic                  push_load;
   logic                  push_done;
   logic [DATA_WIDTH-1:0] push_din;

   // Loading in the cycle the valid strobe arrives keeps the push one cycle behind it.
   always_comb begin
      push_load = 1'b0;
      push_din  = bus.rf_rd_data;
      if (state == RD_WAIT && bus.rf_rd_data_vld) begin
         push_load = 1'b1;
      end else if (state == ALU_WAIT && bus.alu_out_vld) begin
         push_load = 1'b1;
         push_din  = bus.alu_out[DATA_WIDTH-1:0];
      end else if (state == TX_LSB && push_done) begin
         push_load = 1'b1;
         push_din  = res_hi;
      end
   end

   sys_ctrl_tx_push u_push (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (push_load),
      .din       (push_din),
      .fifo_full (bus.fifo_full),
      .tx_p_data (bus.tx_p_data),
      .tx_d_vld  (bus.tx_d_vld),
      .done      (push_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         addr_q          <= '0;
         res_hi          <= '0;
         bus.rf_addr     <= '0;
         bus.rf_wr_data  <= '0;
         bus.rf_wr_en    <= 1'b0;
         bus.rf_rd_en    <= 1'b0;
         bus.alu_en      <= 1'b0;
         bus.alu_fun     <= '0;
         bus.clk_gate_en <= 1'b0;
      end else begin
         bus.rf_wr_en <= 1'b0;
         bus.rf_rd_en <= 1'b0;
         bus.alu_en   <= 1'b0;
         case (state)
            IDLE: if (bus.rx_d_vld) begin
               case (bus.rx_p_data)
                  CMD_WR:     state <= WR_ADDR;
                  CMD_RD:     state <= RD_ADDR;
                  CMD_ALU_WP: state <= ALU_A;
                  CMD_ALU_NP: state <= ALU_FUN;
                  default:    state <= IDLE;
               endcase
            end
            WR_ADDR: if (bus.rx_d_vld) begin
               addr_q <= bus.rx_p_data[ADDR_WIDTH-1:0];
               state  <= WR_DATA;
            end
            WR_DATA: if (bus.rx_d_vld) begin
               bus.rf_addr    <= addr_q;
               bus.rf_wr_data <= bus.rx_p_data;
               bus.rf_wr_en   <= 1'b1;
               state          <= IDLE;
            end
            RD_ADDR: if (bus.rx_d_vld) begin
               bus.rf_addr  <= bus.rx_p_data[ADDR_WIDTH-1:0];
               bus.rf_rd_en <= 1'b1;
               state        <= RD_WAIT;
            end
            RD_WAIT: if (bus.rf_rd_data_vld) state <= TX_RD;
            ALU_A: if (bus.rx_d_vld) begin
               bus.rf_addr    <= OP_A_ADDR;
               bus.rf_wr_data <= bus.rx_p_data;
               bus.rf_wr_en   <= 1'b1;
               state          <= ALU_B;
            end
            ALU_B: if (bus.rx_d_vld) begin
               bus.rf_addr    <= OP_B_ADDR;
               bus.rf_wr_data <= bus.rx_p_data;
               bus.rf_wr_en   <= 1'b1;
               state          <= ALU_FUN;
            end
            ALU_FUN: if (bus.rx_d_vld) begin
               bus.alu_fun     <= bus.rx_p_data[FUN_WIDTH-1:0];
               bus.alu_en      <= 1'b1;
               bus.clk_gate_en <= 1'b1;
               state           <= ALU_WAIT;
            end
            ALU_WAIT: if (bus.alu_out_vld) begin
               res_hi          <= bus.alu_out[ALU_OUT_WIDTH-1:DATA_WIDTH];
               bus.clk_gate_en <= 1'b0;
               state           <= TX_LSB;
            end
            TX_RD:  if (push_done) state <= IDLE;
            TX_LSB: if (push_done) state <= TX_MSB;
            TX_MSB: if (push_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: stimulus pushes expectations, a monitor pops and compares.
module tb_sys_ctrl;
   import sys_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   sys_ctrl_if bus ();

   sys_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int tx_count = 0;
   int rd_lat = 2;
   int alu_lat = 3;
   logic [15:0] alu_ret = 16'h0;
   logic [7:0] mem [16];

   logic [11:0] exp_wr [$];
   logic [3:0]  exp_rd [$];
   logic [3:0]  exp_alu [$];
   logic [7:0]  exp_tx [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s unexpected event actual=%0h required=none", name, act);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_p_data = b;
      bus.rx_d_vld  = 1'b1;
      @(posedge clk); #1;
      bus.rx_d_vld  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rf_addr"},  {28'd0, bus.rf_addr}, 0);
      chk({tag, "_rf_wdata"}, {24'd0, bus.rf_wr_data}, 0);
      chk({tag, "_rf_wr_en"}, {31'd0, bus.rf_wr_en}, 0);
      chk({tag, "_rf_rd_en"}, {31'd0, bus.rf_rd_en}, 0);
      chk({tag, "_alu_en"},   {31'd0, bus.alu_en}, 0);
      chk({tag, "_alu_fun"},  {28'd0, bus.alu_fun}, 0);
      chk({tag, "_clk_gate"}, {31'd0, bus.clk_gate_en}, 0);
      chk({tag, "_tx_data"},  {24'd0, bus.tx_p_data}, 0);
      chk({tag, "_tx_vld"},   {31'd0, bus.tx_d_vld}, 0);
   endtask

   // Register-file read model with programmable latency.
   initial begin
      logic [3:0] a;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rf_rd_en) begin
            a = bus.rf_addr;
            for (int i = 0; i < rd_lat; i++) @(posedge clk);
            #1;
            bus.rf_rd_data     = mem[a];
            bus.rf_rd_data_vld = 1'b1;
            @(posedge clk); #1;
            bus.rf_rd_data_vld = 1'b0;
         end
      end
   end

   // ALU model: returns alu_ret after alu_lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.alu_en) begin
            for (int i = 0; i < alu_lat; i++) @(posedge clk);
            #1;
            bus.alu_out     = alu_ret;
            bus.alu_out_vld = 1'b1;
            @(posedge clk); #1;
            bus.alu_out_vld = 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event.
   initial begin
      logic cg_exp, cg_clr, rdv_prev, aov_prev, full_prev;
      logic [11:0] ew;
      cg_exp = 0; cg_clr = 0; rdv_prev = 0; aov_prev = 0; full_prev = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cg_exp = 0; cg_clr = 0; rdv_prev = 0; aov_prev = 0;
         end else begin
            if (bus.rf_wr_en) begin
               mem[bus.rf_addr] = bus.rf_wr_data;
               if (exp_wr.size() == 0) unexpected("rf_wr", {bus.rf_addr, bus.rf_wr_data});
               else begin
                  ew = exp_wr.pop_front();
                  chk("rf_wr", {20'd0, bus.rf_addr, bus.rf_wr_data}, {20'd0, ew});
               end
            end
            if (bus.rf_rd_en) begin
               if (exp_rd.size() == 0) unexpected("rf_rd", bus.rf_addr);
               else chk("rf_rd_addr", bus.rf_addr, exp_rd.pop_front());
            end
            if (bus.alu_en) begin
               if (exp_alu.size() == 0) unexpected("alu_en", bus.alu_fun);
               else chk("alu_fun", bus.alu_fun, exp_alu.pop_front());
            end
            if (bus.tx_d_vld) begin
               tx_count++;
               if (exp_tx.size() == 0) unexpected("tx_push", bus.tx_p_data);
               else chk("tx_byte", bus.tx_p_data, exp_tx.pop_front());
            end
            if ((rdv_prev || aov_prev) && !full_prev)
               chk("tx_latency", bus.tx_d_vld, 1);
            if (bus.alu_en) cg_exp = 1;
            if (cg_clr) begin cg_exp = 0; cg_clr = 0; end
            if (cg_exp || bus.clk_gate_en) chk("clk_gate_en", bus.clk_gate_en, cg_exp);
            if (bus.alu_out_vld) cg_clr = 1;
            rdv_prev = bus.rf_rd_data_vld;
            aov_prev = bus.alu_out_vld;
         end
         full_prev = bus.fifo_full;
      end
   end

   initial begin
      int txc0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rst_n = 1'b0;
      bus.rx_p_data = 0; bus.rx_d_vld = 0; bus.rf_rd_data = 0; bus.rf_rd_data_vld = 0;
      bus.alu_out = 0; bus.alu_out_vld = 0; bus.fifo_full = 0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // WR then RD
      exp_wr.push_back({4'h0, 8'h05});
      send_byte(CMD_WR); send_byte(8'h00); send_byte(8'h05);
      chk("wr_strobe_n_plus_1", bus.rf_wr_en, 1);
      idle(3);
      exp_rd.push_back(4'h0);
      exp_tx.push_back(8'h05);
      send_byte(CMD_RD); send_byte(8'h00);
      chk("rd_strobe_n_plus_1", bus.rf_rd_en, 1);
      idle(8);

      // ALU with operands: 5,3 fun 1 -> 0x0002
      alu_ret = 16'h0002;
      exp_wr.push_back({4'h0, 8'h05});
      exp_wr.push_back({4'h1, 8'h03});
      exp_alu.push_back(4'h1);
      exp_tx.push_back(8'h02); exp_tx.push_back(8'h00);
      send_byte(CMD_ALU_WP); send_byte(8'h05); send_byte(8'h03); send_byte(8'h01);
      chk("alu_en_n_plus_1", bus.alu_en, 1);
      chk("alu_fun_value", bus.alu_fun, 4'h1);
      chk("clk_gate_rise", bus.clk_gate_en, 1);
      idle(10);

      // ALU without operands -> 0x1234
      alu_ret = 16'h1234;
      exp_alu.push_back(4'h0);
      exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
      send_byte(CMD_ALU_NP); send_byte(8'h00);
      idle(10);

      // Back-pressure: FIFO full across the ALU result
      alu_ret = 16'hBEEF;
      exp_alu.push_back(4'h2);
      exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
      send_byte(CMD_ALU_NP); send_byte(8'h02);
      bus.fifo_full = 1'b1;
      txc0 = tx_count;
      idle(10);
      chk("bp_no_push", tx_count, txc0);
      chk("bp_data_held", bus.tx_p_data, 8'hEF);
      idle(3);
      chk("bp_data_still_held", bus.tx_p_data, 8'hEF);
      bus.fifo_full = 1'b0;
      idle(6);
      chk("bp_two_pushes", tx_count, txc0 + 2);

      // Garbage byte: no activity expected
      send_byte(8'h55);
      idle(4);

      // Abort mid-frame with reset
      send_byte(CMD_WR); send_byte(8'h03);
      rst_n = 1'b0;
      #2;
      check_all_zero("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      exp_wr.push_back({4'h3, 8'h7F});
      send_byte(CMD_WR); send_byte(8'h03); send_byte(8'h7F);
      idle(3);

      // Stray bytes during RD_WAIT are dropped
      rd_lat = 8;
      exp_rd.push_back(4'h3);
      exp_tx.push_back(8'h7F);
      send_byte(CMD_RD); send_byte(8'h03);
      send_byte(CMD_WR); send_byte(8'h55); send_byte(CMD_RD);
      idle(10);
      rd_lat = 2;
      exp_wr.push_back({4'h5, 8'h3C});
      send_byte(CMD_WR); send_byte(8'h05); send_byte(8'h3C);
      idle(3);
      exp_rd.push_back(4'h5);
      exp_tx.push_back(8'h3C);
      send_byte(CMD_RD); send_byte(8'h05);
      idle(10);

      chk("wr_queue_drained",  exp_wr.size(), 0);
      chk("rd_queue_drained",  exp_rd.size(), 0);
      chk("alu_queue_drained", exp_alu.size(), 0);
      chk("tx_queue_drained",  exp_tx.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
